// File: rtl/hash_table_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the hash_table front-end sequencer: op encodings,
// sequencer state type and the default-width request record.
package hash_table_pkg;

    localparam logic [1:0] OP_INSERT  = 2'b00;
    localparam logic [1:0] OP_DELETE  = 2'b01;
    localparam logic [1:0] OP_SEARCH  = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } seq_state_t;

    localparam int DEF_KEY_WIDTH   = 32;
    localparam int DEF_VALUE_WIDTH = 32;
    localparam int DEF_TAG_WIDTH   = 4;

    // Request record at the default widths; the sequencer declares the same
    // field order locally so it can follow its own width parameters.
    typedef struct packed {
        logic [1:0]                 op;
        logic [DEF_KEY_WIDTH-1:0]   key;
        logic [DEF_VALUE_WIDTH-1:0] value;
        logic [DEF_TAG_WIDTH-1:0]   tag;
    } ht_req_t;

endpackage

// File: rtl/hash_req_fifo.sv
`timescale 1ns/1ps
// Small synchronous request FIFO. Pointers carry one extra wrap bit so
// full/empty come from comparing the MSBs; flags are derived from the
// registered pointers, so a pop only frees a slot on the following cycle.
module hash_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; both wrap naturally through the extra MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/hash_table_req_sequencer.sv
`timescale 1ns/1ps
// Front-end for hash_table: buffers tagged requests, issues them one at a
// time over op_en/op_done, and returns tagged responses with error and
// timeout status.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both high; a response transfers on a rising edge where
// resp_valid and resp_ready are both high. While resp_valid is high the
// resp_* fields do not change. Toward hash_table, ht_op_en and the ht_*
// operands stay constant from issue until ht_op_done is sampled high (or the
// timeout fires), and ht_op_en drops on that same edge.
module hash_table_req_sequencer
    import hash_table_pkg::*;
#(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 32,
    parameter int TAG_WIDTH      = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [KEY_WIDTH-1:0]   req_key,
    input  logic [VALUE_WIDTH-1:0] req_value,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [1:0]             resp_op,
    output logic [TAG_WIDTH-1:0]   resp_tag,
    output logic [VALUE_WIDTH-1:0] resp_value,
    output logic                   resp_error,
    output logic                   resp_timeout,
    output logic                   ht_op_en,
    output logic [1:0]             ht_op_sel,
    output logic [KEY_WIDTH-1:0]   ht_key_in,
    output logic [VALUE_WIDTH-1:0] ht_value_in,
    input  logic [VALUE_WIDTH-1:0] ht_value_out,
    input  logic                   ht_op_done,
    input  logic                   ht_op_error,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic [1:0]             op;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
        logic [TAG_WIDTH-1:0]   tag;
    } req_entry_t;

    localparam int ENTRY_W = $bits(req_entry_t);

    seq_state_t         state, state_nxt;
    req_entry_t         wr_entry, head;
    logic [ENTRY_W-1:0] fifo_rd_data;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CNT_W-1:0]   timeout_cnt;
    logic               start_issue, start_illegal, finish_done, finish_timeout;
    logic               timeout_hit;

    assign wr_entry  = '{op: req_op, key: req_key, value: req_value, tag: req_tag};
    assign head      = req_entry_t'(fifo_rd_data);
    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;

    hash_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (wr_entry),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign timeout_hit = (timeout_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-cycle control strobes; the head entry stays in the
    // FIFO while it is in flight and is popped when its response is formed.
    always_comb begin
        state_nxt      = state;
        fifo_pop       = 1'b0;
        start_issue    = 1'b0;
        start_illegal  = 1'b0;
        finish_done    = 1'b0;
        finish_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head.op == OP_ILLEGAL) begin
                        fifo_pop      = 1'b1;
                        start_illegal = 1'b1;
                        state_nxt     = RESP;
                    end else begin
                        start_issue = 1'b1;
                        state_nxt   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (ht_op_done) begin
                    fifo_pop    = 1'b1;
                    finish_done = 1'b1;
                    state_nxt   = RESP;
                end else if (timeout_hit) begin
                    fifo_pop       = 1'b1;
                    finish_timeout = 1'b1;
                    state_nxt      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // hash_table drive registers and the ISSUE cycle counter (1 on the first
    // ISSUE cycle, cleared on exit, bounded by TIMEOUT_CYCLES).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ht_op_en    <= 1'b0;
            ht_op_sel   <= 2'b00;
            ht_key_in   <= '0;
            ht_value_in <= '0;
            timeout_cnt <= '0;
        end else if (start_issue) begin
            ht_op_en    <= 1'b1;
            ht_op_sel   <= head.op;
            ht_key_in   <= head.key;
            ht_value_in <= head.value;
            timeout_cnt <= CNT_W'(1);
        end else if (finish_done || finish_timeout) begin
            ht_op_en    <= 1'b0;
            timeout_cnt <= '0;
        end else if (state == ISSUE) begin
            timeout_cnt <= timeout_cnt + CNT_W'(1);
        end
    end

    // Response holding register, loaded once per request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_op      <= 2'b00;
            resp_tag     <= '0;
            resp_value   <= '0;
            resp_error   <= 1'b0;
            resp_timeout <= 1'b0;
        end else if (start_illegal) begin
            resp_op      <= head.op;
            resp_tag     <= head.tag;
            resp_value   <= '0;
            resp_error   <= 1'b1;
            resp_timeout <= 1'b0;
        end else if (finish_done) begin
            resp_op      <= ht_op_sel;
            resp_tag     <= head.tag;
            resp_value   <= (ht_op_sel == OP_SEARCH) ? ht_value_out : '0;
            resp_error   <= ht_op_error;
            resp_timeout <= 1'b0;
        end else if (finish_timeout) begin
            resp_op      <= ht_op_sel;
            resp_tag     <= head.tag;
            resp_value   <= '0;
            resp_error   <= 1'b1;
            resp_timeout <= 1'b1;
        end
    end

    assign resp_valid = (state == RESP);
    assign busy       = !fifo_empty || (state != IDLE);
    assign dbg_state  = state;

endmodule

// File: tb/tb_hash_table_req_sequencer.sv
`timescale 1ns/1ps
// Bench for hash_table_req_sequencer. A behavioural hash table (8 buckets,
// 4-deep chains) answers the ht_* port with random latency; a request-level
// key/value model predicts every response into exp_q at accept time.
module tb_hash_table_req_sequencer;
    import hash_table_pkg::*;

    localparam int KW    = 32;
    localparam int VW    = 32;
    localparam int TW    = 4;
    localparam int TMO   = 8;
    localparam int EXP_W = 2 + TW + VW + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [KW-1:0] req_key = '0;
    logic [VW-1:0] req_value = '0;
    logic [TW-1:0] req_tag = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [1:0]    resp_op;
    logic [TW-1:0] resp_tag;
    logic [VW-1:0] resp_value;
    logic          resp_error;
    logic          resp_timeout;
    logic          ht_op_en;
    logic [1:0]    ht_op_sel;
    logic [KW-1:0] ht_key_in;
    logic [VW-1:0] ht_value_in;
    logic [VW-1:0] ht_value_out = '0;
    logic          ht_op_done;
    logic          ht_op_error = 1'b0;
    logic          busy;
    logic [1:0]    dbg_state;

    logic rsp_done = 1'b0;
    logic stray_done = 1'b0;
    assign ht_op_done = rsp_done | stray_done;

    int checks = 0;
    int failures = 0;
    logic [EXP_W-1:0] exp_q[$];

    bit stub_hang = 1'b0;
    int lat_min = 0;
    int lat_max = 3;
    int lat = -1;
    int en_cycles = 0;

    logic [KW-1:0] bk_key [8][4];
    logic [VW-1:0] bk_val [8][4];
    logic          bk_vld [8][4] = '{default: '{default: 1'b0}};

    logic [VW-1:0] model_kv [logic [KW-1:0]];

    // clock / reset
    always #5 clk = ~clk;

    hash_table_req_sequencer #(
        .KEY_WIDTH      (KW),
        .VALUE_WIDTH    (VW),
        .TAG_WIDTH      (TW),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_key      (req_key),
        .req_value    (req_value),
        .req_tag      (req_tag),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_op      (resp_op),
        .resp_tag     (resp_tag),
        .resp_value   (resp_value),
        .resp_error   (resp_error),
        .resp_timeout (resp_timeout),
        .ht_op_en     (ht_op_en),
        .ht_op_sel    (ht_op_sel),
        .ht_key_in    (ht_key_in),
        .ht_value_in  (ht_value_in),
        .ht_value_out (ht_value_out),
        .ht_op_done   (ht_op_done),
        .ht_op_error  (ht_op_error),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // Behavioural hash table: performs the operation and raises done once
    task automatic ht_execute();
        int idx;
        int hit;
        int slot;
        idx  = int'(ht_key_in % 32'd8);
        hit  = -1;
        slot = -1;
        for (int w = 0; w < 4; w++) begin
            if (bk_vld[idx][w] && bk_key[idx][w] == ht_key_in) hit = w;
            if (!bk_vld[idx][w] && slot < 0) slot = w;
        end
        ht_value_out = $urandom;
        ht_op_error  = 1'b0;
        case (ht_op_sel)
            OP_INSERT: begin
                if (hit >= 0) bk_val[idx][hit] = ht_value_in;
                else if (slot >= 0) begin
                    bk_vld[idx][slot] = 1'b1;
                    bk_key[idx][slot] = ht_key_in;
                    bk_val[idx][slot] = ht_value_in;
                end else ht_op_error = 1'b1;
            end
            OP_DELETE: begin
                if (hit >= 0) bk_vld[idx][hit] = 1'b0;
                else ht_op_error = 1'b1;
            end
            default: begin
                if (hit >= 0) ht_value_out = bk_val[idx][hit];
                else begin
                    ht_value_out = '0;
                    ht_op_error  = 1'b1;
                end
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (ht_op_en) en_cycles++;
        if (!rst_n || rsp_done) begin
            rsp_done = 1'b0;
            lat = -1;
        end else if (ht_op_en && !stub_hang) begin
            if (lat < 0) lat = $urandom_range(lat_max, lat_min);
            if (lat == 0) begin
                ht_execute();
                rsp_done = 1'b1;
            end else lat--;
        end
    end

    // Request-level reference model: key -> value map, 4 keys per (key % 8)
    function automatic logic [EXP_W-1:0] predict(input logic [1:0] op, input logic [KW-1:0] key,
                                                 input logic [VW-1:0] val, input logic [TW-1:0] tag);
        logic [VW-1:0] rv;
        logic          err;
        int            n;
        rv  = '0;
        err = 1'b0;
        n   = 0;
        case (op)
            OP_INSERT: begin
                if (model_kv.exists(key)) model_kv[key] = val;
                else begin
                    foreach (model_kv[k]) if (k % 8 == key % 8) n++;
                    if (n < 4) model_kv[key] = val;
                    else err = 1'b1;
                end
            end
            OP_DELETE: begin
                if (model_kv.exists(key)) model_kv.delete(key);
                else err = 1'b1;
            end
            OP_SEARCH: begin
                if (model_kv.exists(key)) rv = model_kv[key];
                else err = 1'b1;
            end
            default: err = 1'b1;
        endcase
        return {op, tag, rv, err, 1'b0};
    endfunction

    // Driver: present one request, wait (bounded) for acceptance, predict it
    task automatic send_req(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val,
                            input logic [TW-1:0] tag, input bit will_timeout);
        int budget;
        budget    = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        req_value = val;
        req_tag   = tag;
        while (!req_ready && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL req_accept tag=%0d: req_ready=%b after %0d cycles, required 1", tag, req_ready, budget);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (will_timeout) exp_q.push_back({op, tag, {VW{1'b0}}, 1'b1, 1'b1});
        else exp_q.push_back(predict(op, key, val, tag));
    endtask

    // Scoreboard drain: consume n responses, compare in order, check hold
    task automatic drain(input int n, input bit random_ready);
        int got;
        int cyc;
        logic held;
        logic [EXP_W-1:0] held_v, obs, expv;
        got  = 0;
        cyc  = 0;
        held = 1'b0;
        held_v = '0;
        while (got < n && cyc < 400) begin
            resp_ready = random_ready ? ($urandom_range(1, 0) == 1) : 1'b1;
            obs = {resp_op, resp_tag, resp_value, resp_error, resp_timeout};
            if (held) begin
                checks++;
                if (resp_valid !== 1'b1 || obs !== held_v) begin
                    failures++;
                    $display("FAIL resp_hold: valid=%b fields=%h, required valid=1 fields=%h", resp_valid, obs, held_v);
                end
            end
            held   = resp_valid && !resp_ready;
            held_v = obs;
            if (resp_valid && resp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected: got %h, required no response", obs);
                end else begin
                    expv = exp_q.pop_front();
                    if (obs !== expv) begin
                        failures++;
                        $display("FAIL resp_match {op,tag,value,err,to}: got %h, required %h", obs, expv);
                    end
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        resp_ready = 1'b0;
        checks++;
        if (got != n) begin
            failures++;
            $display("FAIL drain_count: got %0d responses, required %0d", got, n);
        end
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (busy && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks += 6;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b, required 1", req_ready); end
        if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b, required 0", resp_valid); end
        if (ht_op_en !== 1'b0) begin failures++; $display("FAIL reset_ht_op_en: got %b, required 0", ht_op_en); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if ({resp_op, resp_tag, resp_value, resp_error, resp_timeout} !== '0) begin
            failures++; $display("FAIL reset_resp_fields: got %h, required 0", {resp_op, resp_tag, resp_value, resp_error, resp_timeout});
        end
        if ({ht_op_sel, ht_key_in, ht_value_in} !== '0) begin
            failures++; $display("FAIL reset_ht_data: got %h, required 0", {ht_op_sel, ht_key_in, ht_value_in});
        end
    endtask

    task automatic test_insert_search();
        send_req(OP_INSERT, 32'd1, 32'h0000_0002, 4'd1, 1'b0);
        send_req(OP_SEARCH, 32'd1, 32'h0, 4'd2, 1'b0);
        drain(2, 1'b0);
    endtask

    task automatic test_delete_search();
        send_req(OP_DELETE, 32'd1, 32'h0, 4'd3, 1'b0);
        send_req(OP_SEARCH, 32'd1, 32'h0, 4'd4, 1'b0);
        drain(2, 1'b1);
    endtask

    task automatic test_chain_full();
        wait_idle();
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 4; i++) send_req(OP_INSERT, 32'(i * 8), $urandom, 4'(8 + i), 1'b0);
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL fifo_full_ready: req_ready=%b after 4 accepts, required 0", req_ready);
        end
        send_req(OP_INSERT, 32'd32, $urandom, 4'd12, 1'b0);
        drain(5, 1'b0);
        lat_min = 0;
        lat_max = 3;
    endtask

    task automatic test_illegal();
        int en0;
        wait_idle();
        en0 = en_cycles;
        send_req(OP_ILLEGAL, 32'd5, 32'h1234_5678, 4'd5, 1'b0);
        drain(1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (en_cycles != en0) begin
            failures++;
            $display("FAIL illegal_no_access: ht_op_en high %0d cycles, required 0", en_cycles - en0);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        wait_idle();
        stub_hang = 1'b1;
        send_req(OP_SEARCH, 32'd3, 32'h0, 4'd6, 1'b1);
        cyc = 0;
        while (!ht_op_en && cyc < 20) begin @(posedge clk); #1; cyc++; end
        cyc = 0;
        while (!resp_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        checks += 3;
        if (cyc != TMO) begin failures++; $display("FAIL timeout_latency: %0d cycles, required %0d", cyc, TMO); end
        if ({resp_error, resp_timeout} !== 2'b11) begin
            failures++; $display("FAIL timeout_flags: err,to=%b%b, required 11", resp_error, resp_timeout);
        end
        if (ht_op_en !== 1'b0) begin failures++; $display("FAIL timeout_en_drop: ht_op_en=%b, required 0", ht_op_en); end
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        stub_hang = 1'b0;
        drain(1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL stray_done_ignored: resp_valid=%b busy=%b, required 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_reset_mid_op();
        bit stale;
        wait_idle();
        stub_hang = 1'b1;
        for (int i = 0; i < 4; i++) send_req(OP_SEARCH, 32'($urandom_range(23, 0)), 32'h0, 4'(i), 1'b0);
        checks++;
        if (ht_op_en !== 1'b1) begin failures++; $display("FAIL midop_issue: ht_op_en=%b, required 1", ht_op_en); end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (ht_op_en !== 1'b0) begin failures++; $display("FAIL midop_en_async: got %b, required 0", ht_op_en); end
        if (req_ready !== 1'b1) begin failures++; $display("FAIL midop_req_ready: got %b, required 1", req_ready); end
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL midop_valid_busy: resp_valid=%b busy=%b, required 0 0", resp_valid, busy);
        end
        if ({ht_key_in, resp_tag} !== '0) begin
            failures++; $display("FAIL midop_data: got %h, required 0", {ht_key_in, resp_tag});
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stub_hang = 1'b0;
        resp_ready = 1'b1;
        stale = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (resp_valid || busy) stale = 1'b1;
        end
        resp_ready = 1'b0;
        checks++;
        if (stale) begin failures++; $display("FAIL midop_stale: response or busy after reset, required none"); end
    endtask

    task automatic test_back_to_back_random();
        int n;
        int sel;
        logic [1:0] op;
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(4, 1);
            for (int i = 0; i < n; i++) begin
                sel = $urandom_range(9, 0);
                op  = (sel < 4) ? OP_INSERT : (sel < 6) ? OP_DELETE : (sel < 9) ? OP_SEARCH : OP_ILLEGAL;
                send_req(op, 32'($urandom_range(23, 0)), $urandom, 4'($urandom_range(15, 0)), 1'b0);
            end
            drain(n, 1'b1);
        end
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_insert_search();
        test_delete_search();
        test_chain_full();
        test_illegal();
        test_timeout();
        test_reset_mid_op();
        test_back_to_back_random();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty: %0d expected responses left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
